// File: rtl/pla_sweep_checker_pkg.sv
// rtl/pla_sweep_checker_pkg.sv - shared types, constants and MISR arithmetic for the PLA sweep checker
// Contents: state_t (sweep FSM states), DEF_SIG_W / DEF_POLY / DEF_SEED defaults,
//           MAX_SIG_W (widest supported signature), misr_step() single MISR update.
package pla_sweep_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  localparam int          DEF_SIG_W = 16;
  localparam logic [15:0] DEF_POLY  = 16'h1021;
  localparam logic [15:0] DEF_SEED  = 16'hFFFF;

  // Signatures up to this width share the one step function below.
  localparam int          MAX_SIG_W = 32;

  // One MISR update: shift left, fold the polynomial in when the bit shifted
  // out was set, then absorb the sample. Only the low 'width' bits are meaningful.
  function automatic logic [MAX_SIG_W-1:0] misr_step(
    input logic [MAX_SIG_W-1:0] sig,
    input logic [MAX_SIG_W-1:0] data,
    input logic [MAX_SIG_W-1:0] poly,
    input int                   width
  );
    logic [MAX_SIG_W-1:0] mask;
    logic [MAX_SIG_W-1:0] nxt;
    mask = (width >= MAX_SIG_W) ? '1 : ((MAX_SIG_W'(1) << width) - MAX_SIG_W'(1));
    nxt  = (sig << 1) ^ (sig[width-1] ? poly : '0) ^ data;
    return nxt & mask;
  endfunction

endpackage

// File: rtl/pla_sweep_checker_if.sv
// rtl/pla_sweep_checker_if.sv - control, result and PLA-side signals of the sweep checker
// Signals: start, abort, exp_sig (sweep control); busy, done, pass, signature, vec_count (result);
//          pla_x (stimulus to PLA), pla_z (PLA response).
// Modports: slave = checker side, master = controller/PLA side.
interface pla_sweep_checker_if
  import pla_sweep_checker_pkg::*;
#(
  parameter int NIN   = 15,
  parameter int NOUT  = 11,
  parameter int SIG_W = DEF_SIG_W
);

  logic             start;
  logic             abort;
  logic [SIG_W-1:0] exp_sig;
  logic [NIN-1:0]   pla_x;
  logic [NOUT-1:0]  pla_z;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [NIN:0]     vec_count;

  modport slave (
    input  start, abort, exp_sig, pla_z,
    output pla_x, busy, done, pass, signature, vec_count
  );

  modport master (
    output start, abort, exp_sig, pla_z,
    input  pla_x, busy, done, pass, signature, vec_count
  );

endinterface

// File: rtl/pla_sweep_misr.sv
// rtl/pla_sweep_misr.sv - multiple-input signature register compacting PLA samples
// Ports: clk, rst (async, active-high); load (reload SEED); enable (absorb data);
//        data (zero-extended PLA outputs); signature (current value); sig_next (value after one step).
module pla_sweep_misr
  import pla_sweep_checker_pkg::*;
#(
  parameter int               SIG_W = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] signature,
  output logic [SIG_W-1:0] sig_next
);

  logic [SIG_W-1:0] sig_q;

  assign sig_next = SIG_W'(misr_step(MAX_SIG_W'(sig_q), MAX_SIG_W'(data),
                                     MAX_SIG_W'(POLY), SIG_W));

  // load wins over enable so a new sweep always starts from the seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else if (load) begin
      sig_q <= SEED;
    end else if (enable) begin
      sig_q <= sig_next;
    end
  end

  assign signature = sig_q;

endmodule

// File: rtl/pla_sweep_checker.sv
// rtl/pla_sweep_checker.sv - exhaustive PLA input sweep with MISR compaction and signature compare
// Ports: clk, rst (async, active-high); bus (slave modport of pla_sweep_checker_if):
//        start/abort/exp_sig in, pla_x out to the PLA, pla_z in from the PLA,
//        busy/done/pass/signature/vec_count out.
module pla_sweep_checker
  import pla_sweep_checker_pkg::*;
#(
  parameter int               NIN    = 15,
  parameter int               NOUT   = 11,
  parameter int               SIG_W  = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
  parameter int               SETTLE = 0
) (
  input logic                 clk,
  input logic                 rst,
  pla_sweep_checker_if.slave  bus
);

  localparam logic [3:0] SETTLE_CNT  = 4'(SETTLE);
  // With no settle time every edge samples, so the WAIT state is skipped.
  localparam state_t     FIRST_STATE = (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;

  state_t           state_q, state_d;
  logic [NIN-1:0]   x_q, x_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SIG_W-1:0] exp_q, exp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [NIN:0]     vc_q, vc_d;

  logic             misr_load;
  logic             misr_en;
  logic [SIG_W-1:0] z_ext;
  logic [SIG_W-1:0] sig;
  logic [SIG_W-1:0] sig_next;

  assign z_ext = SIG_W'(bus.pla_z);

  pla_sweep_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk       (clk),
    .rst       (rst),
    .load      (misr_load),
    .enable    (misr_en),
    .data      (z_ext),
    .signature (sig),
    .sig_next  (sig_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      vc_q    <= vc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    vc_d      = vc_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          x_d       = '0;
          vc_d      = '0;
          exp_d     = bus.exp_sig;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = SETTLE_CNT;
          misr_load = 1'b1;
          state_d   = FIRST_STATE;
        end
      end

      ST_WAIT: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          x_d     = '0;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_SAMPLE: begin
        // abort beats the sample, including the final one: nothing is absorbed.
        if (bus.abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          x_d     = '0;
        end else begin
          misr_en = 1'b1;
          vc_d    = vc_q + (NIN+1)'(1);
          if (&x_q) begin
            // Compare against the post-step value so pass lines up with done.
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (sig_next == exp_q);
            state_d = ST_IDLE;
          end else begin
            x_d     = x_q + NIN'(1);
            cnt_d   = SETTLE_CNT;
            state_d = FIRST_STATE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.pla_x     = x_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig;
  assign bus.vec_count = vc_q;

endmodule

// File: tb/tb_pla_sweep_checker.sv
// tb/tb_pla_sweep_checker.sv - randomized self-checking bench for pla_sweep_checker
module tb_pla_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] key_c = '0;

  pla_sweep_checker_if #(.NIN(2), .NOUT(1), .SIG_W(16)) if_a ();
  pla_sweep_checker_if #(.NIN(2), .NOUT(1), .SIG_W(16)) if_b ();
  pla_sweep_checker_if #(.NIN(15), .NOUT(11), .SIG_W(16)) if_c ();

  // Stub PLA used by the full-size instance; key varies the truth table per run.
  function automatic logic [10:0] stub_c(input logic [14:0] x, input logic [10:0] key);
    logic [14:0] p;
    p = x * 15'h2B5;
    return p[10:0] ^ key ^ {x[14:11], x[6:0]};
  endfunction

  assign if_a.pla_z = if_a.pla_x[0] & if_a.pla_x[1];
  assign if_b.pla_z = if_b.pla_x[0] & if_b.pla_x[1];
  assign if_c.pla_z = stub_c(if_c.pla_x, key_c);

  pla_sweep_checker #(.NIN(2), .NOUT(1), .SETTLE(0)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  pla_sweep_checker #(.NIN(2), .NOUT(1), .SETTLE(3)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  pla_sweep_checker u_c (.clk(clk), .rst(rst), .bus(if_c));

  // Reference signature: CRC-style MISR over every vector in ascending order.
  function automatic logic [15:0] model_sig(input int nvec, input logic [10:0] key);
    logic [15:0] s;
    logic [10:0] z;
    s = 16'hFFFF;
    for (int i = 0; i < nvec; i++) begin
      z = stub_c(15'(i), key);
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {5'd0, z};
    end
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic sweep_a(input logic [15:0] e, input int runs);
    int k;
    @(negedge clk);
    if_a.exp_sig = e;
    if_a.start   = 1'b1;
    for (int r = 0; r < runs; r++) begin
      @(negedge clk);
      if_a.start = 1'b0;
      check_eq("a_busy_accept", if_a.busy, 1);
      check_eq("a_vec_accept", if_a.vec_count, 0);
      k = 0;
      while (!if_a.done && k < 64) begin
        @(negedge clk);
        k++;
      end
      check_eq("a_done_latency", k, 4);
      check_eq("a_signature", if_a.signature, 16'h0E1E);
      check_eq("a_pass", if_a.pass, e == 16'h0E1E);
      check_eq("a_vec_count", if_a.vec_count, 4);
      check_eq("a_busy_end", if_a.busy, 0);
      if (r < runs - 1) if_a.start = 1'b1;
    end
    @(negedge clk);
    check_eq("a_done_width", if_a.done, 0);
    check_eq("a_pass_hold", if_a.pass, e == 16'h0E1E);
    check_eq("a_sig_hold", if_a.signature, 16'h0E1E);
  endtask

  task automatic sweep_b(input logic [15:0] e);
    int k;
    int bad;
    @(negedge clk);
    if_b.exp_sig = e;
    if_b.start   = 1'b1;
    @(negedge clk);
    if_b.start = 1'b0;
    k   = 0;
    bad = (if_b.pla_x != 2'd0) ? 1 : 0;
    while (!if_b.done && k < 128) begin
      @(negedge clk);
      k++;
      if (k < 16 && int'(if_b.pla_x) != k / 4) bad++;
    end
    check_eq("b_hold_errors", bad, 0);
    check_eq("b_done_latency", k, 16);
    check_eq("b_pla_x_last", if_b.pla_x, 3);
    check_eq("b_signature", if_b.signature, 16'h0E1E);
    check_eq("b_pass", if_b.pass, e == 16'h0E1E);
    check_eq("b_vec_count", if_b.vec_count, 4);
  endtask

  task automatic sweep_c();
    int k;
    logic [15:0] m;
    logic [15:0] e;
    key_c = 11'($urandom);
    m     = model_sig(32768, key_c);
    e     = ($urandom_range(0, 1) == 1) ? m : (m ^ 16'($urandom_range(1, 65535)));
    @(negedge clk);
    if_c.exp_sig = e;
    if_c.start   = 1'b1;
    @(negedge clk);
    if_c.start = 1'b0;
    k = 0;
    while (!if_c.done && k < 40000) begin
      @(negedge clk);
      k++;
    end
    check_eq("c_done_latency", k, 32768);
    check_eq("c_signature", if_c.signature, m);
    check_eq("c_pass", if_c.pass, e == m);
    check_eq("c_vec_count", if_c.vec_count, 32768);
    @(negedge clk);
    check_eq("c_done_width", if_c.done, 0);
    check_eq("c_sig_hold", if_c.signature, m);
  endtask

  initial begin
    int dones;
    logic [15:0] e;
    if_a.start = 1'b0; if_a.abort = 1'b0; if_a.exp_sig = '0;
    if_b.start = 1'b0; if_b.abort = 1'b0; if_b.exp_sig = '0;
    if_c.start = 1'b0; if_c.abort = 1'b0; if_c.exp_sig = '0;

    #12;
    check_eq("rst_a_busy", if_a.busy, 0);
    check_eq("rst_a_done", if_a.done, 0);
    check_eq("rst_a_pass", if_a.pass, 0);
    check_eq("rst_c_sig", if_c.signature, 0);
    check_eq("rst_c_vec", if_c.vec_count, 0);
    check_eq("rst_c_pla_x", if_c.pla_x, 0);
    @(negedge clk);
    rst = 1'b0;

    sweep_a(16'h0E1E, 1);
    sweep_a(16'h0E1F, 1);
    for (int i = 0; i < 4; i++) begin
      e = ($urandom_range(0, 1) == 1) ? 16'h0E1E : 16'($urandom);
      sweep_a(e, int'($urandom_range(1, 3)));
    end

    sweep_b(16'h0E1E);
    sweep_b(16'($urandom));

    // abort while idle changes nothing
    @(negedge clk);
    if_a.abort = 1'b1;
    @(negedge clk);
    if_a.abort = 1'b0;
    check_eq("idle_abort_busy", if_a.busy, 0);
    check_eq("idle_abort_sig", if_a.signature, 16'h0E1E);

    // second start ignored while busy, then abort on the last-vector edge
    if_a.exp_sig = 16'h0E1E;
    if_a.start   = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    if_a.abort = 1'b1;
    @(negedge clk);
    if_a.abort = 1'b0;
    check_eq("abort_busy", if_a.busy, 0);
    check_eq("abort_done", if_a.done, 0);
    check_eq("abort_pass", if_a.pass, 0);
    check_eq("abort_pla_x", if_a.pla_x, 0);
    check_eq("abort_vec_count", if_a.vec_count, 3);
    check_eq("abort_sig", if_a.signature, 16'h8F1F);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if_a.done) dones++;
    end
    check_eq("abort_no_done", dones, 0);
    check_eq("abort_vec_frozen", if_a.vec_count, 3);
    check_eq("abort_sig_frozen", if_a.signature, 16'h8F1F);

    // asynchronous reset mid-sweep
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("arst_busy", if_a.busy, 0);
    check_eq("arst_pla_x", if_a.pla_x, 0);
    check_eq("arst_sig", if_a.signature, 0);
    check_eq("arst_vec", if_a.vec_count, 0);
    check_eq("arst_pass", if_a.pass, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if_a.done) dones++;
    end
    check_eq("arst_no_done", dones, 0);
    sweep_a(16'h0E1E, 1);

    sweep_c();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pla_sweep_checker.md
Name: pla_sweep_checker

Overview:
- Stimulus and response end of a combinational PLA block with 15 inputs (x00..x14) and 11 outputs (z00..z10).
- On start, drives every input vector 0..2^NIN-1 onto the PLA in ascending order and samples the outputs after a programmable settle time.
- Compacts the samples into a MISR signature and compares it against an expected signature.
- Sits beside any generated PLA as a built-in self-test / equivalence harness.

Parameters:
- NIN, 15, PLA input width; the sweep covers 2^NIN vectors.
- NOUT, 11, PLA output width (NOUT <= SIG_W).
- SIG_W, 16, MISR width.
- POLY, 16'h1021, MISR feedback taps.
- SEED, 16'hFFFF, MISR value loaded at sweep start.
- SETTLE, 0, extra wait cycles between a pla_x change and its sample (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a sweep; accepted only in IDLE.
- abort  in  1  cancels a running sweep.
- exp_sig  in  SIG_W  expected final signature; sampled at the start-accept edge.
- pla_x  out  NIN  registered stimulus to the PLA inputs.
- pla_z  in  NOUT  PLA outputs; combinational from pla_x.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  signature == captured exp_sig; valid from the done pulse until the next start.
- signature  out  SIG_W  MISR value; final result holds after done.
- vec_count  out  NIN+1  number of vectors sampled in the current or last sweep.

Behaviour:
- Reset (async, rst=1) forces: state IDLE, pla_x=0, busy=0, done=0, pass=0, signature=0, vec_count=0, settle counter=0. Reset mid-sweep abandons the sweep; no done is produced.
- States are IDLE, WAIT and SAMPLE.
- IDLE, start=1 at a clock edge (start-accept edge):
  - pla_x <= 0, signature <= SEED, vec_count <= 0, exp register <= exp_sig, pass <= 0, busy <= 1.
  - Settle counter <= SETTLE.
  - Next state = WAIT if SETTLE>0, else SAMPLE.
- WAIT: decrement the settle counter each edge; go to SAMPLE on the edge where it reaches 0.
- SAMPLE edge:
  - signature <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended pla_z.
  - vec_count <= vec_count+1.
  - If pla_x is all ones (last vector): done <= 1, busy <= 0, pass <= (next signature == exp register), go to IDLE. pla_x holds its last value.
  - Otherwise: pla_x <= pla_x+1, reload the settle counter, go to WAIT or SAMPLE as from IDLE.
- Cycle budget: each vector takes SETTLE+1 cycles. The done pulse is visible 2^NIN*(SETTLE+1) cycles after the start-accept edge.
- done is high for exactly one cycle. pass and signature are stable while IDLE.
- start while busy: ignored, no effect on the running sweep.
- start in the same cycle as done (i.e. already IDLE): accepted normally.
- abort while busy:
  - Next edge goes to IDLE with busy=0, pass=0, no done, pla_x <= 0.
  - signature and vec_count freeze at their partial values.
  - abort has priority over a coincident last-vector SAMPLE.
- abort in IDLE: no effect.
- vec_count is NIN+1 bits so that 2^NIN (32768 for NIN=15) is representable without wrap.

Decomposition:
- Shared package: state enum, the default POLY and SEED constants, and a MISR step function so the bench reference model uses identical arithmetic.
- One sub-module is natural: pla_sweep_misr (SIG_W, POLY; load, enable, data in; signature out).
- The FSM, counters and compare stay in the top module.

Test Plan:
1. NIN=2, NOUT=1, SETTLE=0, stub pla_z = x0&x1 (z sequence 0,0,0,1), start with exp_sig=16'h0E1E.
   - MISR steps EFDF, CF9F, 8F1F, 0E1E.
   - done high exactly 4 cycles after the accept edge, pass=1, vec_count=4.
2. Same as scenario 1 with exp_sig=16'h0E1F.
   - signature=0E1E, pass=0.
3. NIN=2, SETTLE=3.
   - pla_x holds each value for 4 cycles.
   - done 16 cycles after accept, same signature 0E1E.
4. Default parameters with a stub PLA and a software model of the MISR.
   - vec_count=32768, done after 32768 cycles.
   - signature matches the model; pass follows exp_sig.
5. Pulse start again at cycle 2 of a sweep, then assert abort at cycle 3.
   - The second start is ignored.
   - After abort: busy=0 next cycle, no done pulse, pass=0, pla_x=0, vec_count=3 (vectors 0..2 sampled) frozen.
6. Assert rst at cycle 2 of a sweep.
   - All outputs go to reset values immediately (asynchronous), no done pulse.
   - A subsequent start runs a full sweep with the correct signature.
